data_mem_dump_arbiter: RTL and testbench
========================================

// Module: data_mem_dump_arbiter
// PURPOSE
//  Shares the single Data_Memory port between the pipeline MEM stage and the debug unit.
//  On a debug dump command, it sequences word reads over an address range.
//  Each read word is handed to the debug side with a valid/ready handshake.
//  The pipeline always has priority and is never stalled; dump reads use idle port cycles.
// PARAMETERS
//  NBITS      32     data/address width
//  CNT_W      8      width of dump word counter (max 2^CNT_W-1 words)
//  SIZE_WORD  2'b11  i_flg_mem_size encoding for a full-word access
//  ADDR_STEP  4      byte increment between dumped words
// PORTS
//  i_clk            in   1       clock, rising edge
//  i_rst            in   1       async reset, active-low
//  i_pipe_req       in   1       MEM stage has a memory op this cycle
//  i_pipe_we        in   1       1 = store, 0 = load
//  i_pipe_size      in   2       access size from MEM stage
//  i_pipe_unsigned  in   1       zero-extend loads
//  i_pipe_addr      in   NBITS   effective address from MEM stage
//  i_pipe_wdata     in   NBITS   store data
//  o_pipe_rdata     out  NBITS   load data (= i_mem_rdata, combinational)
//  i_dbg_start      in   1       start-dump pulse
//  i_dbg_base       in   NBITS   first byte address of dump
//  i_dbg_words      in   CNT_W   number of words to dump
//  i_dbg_ready      in   1       debug side accepts o_dbg_data
//  o_dbg_valid      out  1       o_dbg_data/o_dbg_addr hold a dumped word
//  o_dbg_data       out  NBITS   dumped word
//  o_dbg_addr       out  NBITS   address of dumped word
//  o_dbg_busy       out  1       dump in progress
//  o_dbg_done       out  1       one-cycle pulse at end of dump
//  o_mem_we         out  1       to Data_Memory i_write_en
//  o_mem_size       out  2       to Data_Memory i_size
//  o_mem_unsigned   out  1       to Data_Memory i_unsigned
//  o_mem_addr       out  NBITS   to Data_Memory i_addr
//  o_mem_wdata      out  NBITS   to Data_Memory i_data_in
//  i_mem_rdata      in   NBITS   from Data_Memory o_data_out (registered read, valid 1 cycle after addr)
// BEHAVIOUR
//  Reset (i_rst=0, async): state=IDLE; addr/count regs=0; o_dbg_valid/busy/done=0; o_dbg_data=0.
//  The FSM is registered, with states IDLE, RD, WAIT, SEND and DONE.
//  Port mux (combinational):
//   - Dump owns the port only when state==RD && !i_pipe_req.
//     It drives addr=cur_addr, size=SIZE_WORD, unsigned=1, we=0, wdata=0.
//   - Otherwise the pipeline owns the port: we=i_pipe_req&i_pipe_we, other fields pass through.
//  IDLE:
//   - i_dbg_start && i_dbg_words!=0 -> load cur_addr=i_dbg_base and remaining=i_dbg_words; go to RD.
//   - i_dbg_start && i_dbg_words==0 -> go to DONE (no memory reads).
//  RD:
//   - Granted (!i_pipe_req) -> WAIT.
//   - Otherwise stay in RD and retry next cycle; there is no limit on retries.
//  WAIT: capture o_dbg_data<=i_mem_rdata and o_dbg_addr<=cur_addr; set o_dbg_valid; go to SEND.
//   - The port is free for the pipeline in WAIT.
//  SEND: hold o_dbg_valid, o_dbg_data and o_dbg_addr stable until i_dbg_ready=1 at a clock edge. Then:
//   - clear o_dbg_valid;
//   - if remaining==1 -> DONE;
//   - else remaining-=1, cur_addr+=ADDR_STEP (mod 2^NBITS, wraps), go to RD.
//  DONE: o_dbg_done=1 for exactly this cycle; go to IDLE.
//  o_dbg_busy=1 in every state except IDLE, including DONE.
//  Best case is 3 cycles per word: RD, WAIT, SEND with ready already high.
//  i_dbg_start outside IDLE is ignored. Async reset mid-dump aborts to IDLE, with no done pulse.
//  A pipeline store to a dumped address during a dump is legal; the dump returns whatever the read samples.
// TESTING
//  1. Reset, base=0x10, words=3, ready=1, no pipe req
//     -> reads at 0x10/0x14/0x18; 3 valid beats 3 cycles apart; done pulse once.
//  2. Same dump with i_pipe_req=1 held for 5 cycles during RD
//     -> mem follows pipe addr, dump stalls in RD, then resumes; no pipe stall.
//  3. Hold i_dbg_ready=0 for 4 cycles in SEND
//     -> o_dbg_valid/data/addr stable, no new mem read issued.
//  4. words=0 -> no dump mem access; busy high 1 cycle, done pulse next cycle after start.
//  5. base=0xFFFFFFFC, words=2 -> second read address is 0x00000000 (wrap).
//  6. Assert i_rst=0 while in SEND
//     -> outputs clear immediately (async); start afterwards works normally; pipe store passes we=1.

Source files
------------

// File: rtl/data_mem_dump_arbiter.sv
// Shares the Data_Memory port between the pipeline MEM stage and a debug
// memory dump engine. The pipeline always wins; dump reads use idle cycles.
//
// Ports:
//   i_clk, i_rst          clock, async active-low reset
//   i_pipe_*              MEM-stage request (req/we/size/unsigned/addr/wdata)
//   o_pipe_rdata          load data back to MEM stage (pass-through)
//   i_dbg_start/base/words  dump command (pulse, first byte addr, word count)
//   i_dbg_ready           debug side accepts the presented word
//   o_dbg_valid/data/addr dumped word handshake
//   o_dbg_busy/done       dump in progress / one-cycle end pulse
//   o_mem_*               Data_Memory request fields
//   i_mem_rdata           Data_Memory read data (one cycle after address)

module data_mem_dump_arbiter #(
  parameter int         NBITS     = 32,
  parameter int         CNT_W     = 8,
  parameter logic [1:0] SIZE_WORD = 2'b11,
  parameter int         ADDR_STEP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pipe_req,
  input  logic             i_pipe_we,
  input  logic [1:0]       i_pipe_size,
  input  logic             i_pipe_unsigned,
  input  logic [NBITS-1:0] i_pipe_addr,
  input  logic [NBITS-1:0] i_pipe_wdata,
  output logic [NBITS-1:0] o_pipe_rdata,
  input  logic             i_dbg_start,
  input  logic [NBITS-1:0] i_dbg_base,
  input  logic [CNT_W-1:0] i_dbg_words,
  input  logic             i_dbg_ready,
  output logic             o_dbg_valid,
  output logic [NBITS-1:0] o_dbg_data,
  output logic [NBITS-1:0] o_dbg_addr,
  output logic             o_dbg_busy,
  output logic             o_dbg_done,
  output logic             o_mem_we,
  output logic [1:0]       o_mem_size,
  output logic             o_mem_unsigned,
  output logic [NBITS-1:0] o_mem_addr,
  output logic [NBITS-1:0] o_mem_wdata,
  input  logic [NBITS-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [NBITS-1:0] STEP = NBITS'(ADDR_STEP);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [NBITS-1:0] r_cur_addr;
  logic [NBITS-1:0] w_cur_addr_nx;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remaining_nx;
  logic             r_dbg_valid;
  logic             w_dbg_valid_nx;
  logic [NBITS-1:0] r_dbg_data;
  logic [NBITS-1:0] w_dbg_data_nx;
  logic [NBITS-1:0] r_dbg_addr;
  logic [NBITS-1:0] w_dbg_addr_nx;
  logic             w_dump_grant;

  // Dump reads only when the pipeline leaves the port idle.
  assign w_dump_grant = (r_state == S_RD) && !i_pipe_req;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_dbg_valid <= 1'b0;
      r_dbg_data  <= '0;
      r_dbg_addr  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cur_addr  <= w_cur_addr_nx;
      r_remaining <= w_remaining_nx;
      r_dbg_valid <= w_dbg_valid_nx;
      r_dbg_data  <= w_dbg_data_nx;
      r_dbg_addr  <= w_dbg_addr_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cur_addr_nx  = r_cur_addr;
    w_remaining_nx = r_remaining;
    w_dbg_valid_nx = r_dbg_valid;
    w_dbg_data_nx  = r_dbg_data;
    w_dbg_addr_nx  = r_dbg_addr;
    unique case (r_state)
      S_IDLE: begin
        if (i_dbg_start) begin
          if (i_dbg_words != '0) begin
            w_cur_addr_nx  = i_dbg_base;
            w_remaining_nx = i_dbg_words;
            w_state_nx     = S_RD;
          end else begin
            w_state_nx = S_DONE;
          end
        end
      end
      S_RD: begin
        if (w_dump_grant) begin
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // Registered memory: read data for cur_addr is present now.
        w_dbg_data_nx  = i_mem_rdata;
        w_dbg_addr_nx  = r_cur_addr;
        w_dbg_valid_nx = 1'b1;
        w_state_nx     = S_SEND;
      end
      S_SEND: begin
        if (i_dbg_ready) begin
          w_dbg_valid_nx = 1'b0;
          if (r_remaining == ONE) begin
            w_state_nx = S_DONE;
          end else begin
            w_remaining_nx = r_remaining - ONE;
            w_cur_addr_nx  = r_cur_addr + STEP;
            w_state_nx     = S_RD;
          end
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_mem_we       = i_pipe_req & i_pipe_we;
    o_mem_size     = i_pipe_size;
    o_mem_unsigned = i_pipe_unsigned;
    o_mem_addr     = i_pipe_addr;
    o_mem_wdata    = i_pipe_wdata;
    if (w_dump_grant) begin
      o_mem_we       = 1'b0;
      o_mem_size     = SIZE_WORD;
      o_mem_unsigned = 1'b1;
      o_mem_addr     = r_cur_addr;
      o_mem_wdata    = '0;
    end
  end

  assign o_pipe_rdata = i_mem_rdata;
  assign o_dbg_valid  = r_dbg_valid;
  assign o_dbg_data   = r_dbg_data;
  assign o_dbg_addr   = r_dbg_addr;
  assign o_dbg_busy   = (r_state != S_IDLE);
  assign o_dbg_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_data_mem_dump_arbiter.sv
// Scoreboard bench for data_mem_dump_arbiter: expected dump words are queued
// at start and popped as each valid beat appears.

module tb_data_mem_dump_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_pipe_req;
  logic        i_pipe_we;
  logic [1:0]  i_pipe_size;
  logic        i_pipe_unsigned;
  logic [31:0] i_pipe_addr;
  logic [31:0] i_pipe_wdata;
  logic [31:0] o_pipe_rdata;
  logic        i_dbg_start;
  logic [31:0] i_dbg_base;
  logic [7:0]  i_dbg_words;
  logic        i_dbg_ready;
  logic        o_dbg_valid;
  logic [31:0] o_dbg_data;
  logic [31:0] o_dbg_addr;
  logic        o_dbg_busy;
  logic        o_dbg_done;
  logic        o_mem_we;
  logic [1:0]  o_mem_size;
  logic        o_mem_unsigned;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  data_mem_dump_arbiter dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pipe_req     (i_pipe_req),
    .i_pipe_we      (i_pipe_we),
    .i_pipe_size    (i_pipe_size),
    .i_pipe_unsigned(i_pipe_unsigned),
    .i_pipe_addr    (i_pipe_addr),
    .i_pipe_wdata   (i_pipe_wdata),
    .o_pipe_rdata   (o_pipe_rdata),
    .i_dbg_start    (i_dbg_start),
    .i_dbg_base     (i_dbg_base),
    .i_dbg_words    (i_dbg_words),
    .i_dbg_ready    (i_dbg_ready),
    .o_dbg_valid    (o_dbg_valid),
    .o_dbg_data     (o_dbg_data),
    .o_dbg_addr     (o_dbg_addr),
    .o_dbg_busy     (o_dbg_busy),
    .o_dbg_done     (o_dbg_done),
    .o_mem_we       (o_mem_we),
    .o_mem_size     (o_mem_size),
    .o_mem_unsigned (o_mem_unsigned),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Registered-read memory model
  always @(posedge i_clk) i_mem_rdata <= mem_word(o_mem_addr);
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) if (o_dbg_done) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_dump(input logic [31:0] base,
                            input logic [7:0] words);
    for (int i = 0; i < int'(words); i++) begin
      sb.push_back('{a: base + 32'(4 * i),
                     d: mem_word(base + 32'(4 * i))});
    end
    i_dbg_base  = base;
    i_dbg_words = words;
    i_dbg_start = 1'b1;
    tick();
    i_dbg_start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge i_clk);
      if (o_dbg_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge i_clk);
      if (!o_dbg_busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    i_pipe_req = 1'b0;
    i_pipe_we = 1'b1;
    i_pipe_size = 2'b01;
    i_pipe_unsigned = 1'b0;
    i_pipe_addr = 32'h0000_0100;
    i_pipe_wdata = 32'h1234_5678;
    i_dbg_start = 1'b0;
    i_dbg_base = '0;
    i_dbg_words = '0;
    i_dbg_ready = 1'b1;
    #2;
    n_checks++;
    if ({o_dbg_valid, o_dbg_busy, o_dbg_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {o_dbg_valid, o_dbg_busy, o_dbg_done});
    end
    n_checks++;
    if (o_dbg_data !== 32'h0 || o_dbg_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h/%h want 0/0",
               o_dbg_data, o_dbg_addr);
    end
    n_checks++;
    if (o_mem_we !== 1'b0 || o_mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL reset_mux: got we=%b a=%h want we=0 a=100",
               o_mem_we, o_mem_addr);
    end
    tick();
    tick();
    i_rst = 1'b1;
    i_pipe_we = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit   ok;
    exp_t e;
    int   last;
    int   d0;
    last = 0;
    d0 = done_cnt;
    i_dbg_ready = 1'b1;
    start_dump(32'h10, 8'd3);
    @(negedge i_clk);
    n_checks++;
    if (o_mem_addr !== 32'h10 || o_mem_size !== 2'b11 ||
        o_mem_unsigned !== 1'b1 || o_mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_rd_port: got a=%h s=%b u=%b we=%b want 10/11/1/0",
               o_mem_addr, o_mem_size, o_mem_unsigned, o_mem_we);
    end
    for (int k = 0; k < 3; k++) begin
      wait_valid(20, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL basic_beat_timeout: got no valid want beat %0d", k);
      end else begin
        e = sb.pop_front();
        if (o_dbg_addr !== e.a || o_dbg_data !== e.d) begin
          n_fail++;
          $display("FAIL basic_beat: got %h/%h want %h/%h",
                   o_dbg_addr, o_dbg_data, e.a, e.d);
        end
        if (k > 0) begin
          n_checks++;
          if (cyc - last !== 3) begin
            n_fail++;
            $display("FAIL basic_spacing: got %0d want 3", cyc - last);
          end
        end
        last = cyc;
      end
    end
    wait_idle(20, ok);
    n_checks++;
    if (!ok || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL basic_done: got idle=%b pulses=%0d want 1/1",
               ok, done_cnt - d0);
    end
  endtask

  task automatic test_pipe_priority();
    bit   ok;
    exp_t e;
    i_pipe_req = 1'b1;
    i_pipe_we = 1'b1;
    i_pipe_size = 2'b10;
    i_pipe_addr = 32'h200;
    i_pipe_wdata = 32'hCAFE_0001;
    start_dump(32'h10, 8'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_mem_addr !== 32'h200 || o_mem_we !== 1'b1 ||
          o_mem_wdata !== 32'hCAFE_0001 || o_mem_size !== 2'b10 ||
          o_dbg_valid !== 1'b0 || o_dbg_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL prio_pipe_owns: got a=%h we=%b v=%b b=%b want 200/1/0/1",
                 o_mem_addr, o_mem_we, o_dbg_valid, o_dbg_busy);
      end
      tick();
    end
    n_checks++;
    if (o_pipe_rdata !== mem_word(32'h200)) begin
      n_fail++;
      $display("FAIL prio_rdata: got %h want %h",
               o_pipe_rdata, mem_word(32'h200));
    end
    i_pipe_req = 1'b0;
    i_pipe_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(20, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL prio_beat_timeout: got no valid want beat %0d", k);
      end else begin
        e = sb.pop_front();
        if (o_dbg_addr !== e.a || o_dbg_data !== e.d) begin
          n_fail++;
          $display("FAIL prio_beat: got %h/%h want %h/%h",
                   o_dbg_addr, o_dbg_data, e.a, e.d);
        end
      end
    end
    wait_idle(20, ok);
  endtask

  task automatic test_ready_stall();
    bit          ok;
    exp_t        e;
    logic [31:0] hd;
    logic [31:0] ha;
    i_pipe_addr = 32'h300;
    i_dbg_ready = 1'b0;
    start_dump(32'h40, 8'd2);
    wait_valid(20, ok);
    hd = o_dbg_data;
    ha = o_dbg_addr;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_timeout: got no valid want valid");
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge i_clk);
      n_checks++;
      if (o_dbg_valid !== 1'b1 || o_dbg_data !== hd ||
          o_dbg_addr !== ha || o_mem_addr !== 32'h300) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b %h/%h ma=%h want 1 %h/%h 300",
                 o_dbg_valid, o_dbg_addr, o_dbg_data, o_mem_addr, ha, hd);
      end
    end
    e = sb.pop_front();
    n_checks++;
    if (ha !== e.a || hd !== e.d) begin
      n_fail++;
      $display("FAIL stall_beat: got %h/%h want %h/%h", ha, hd, e.a, e.d);
    end
    i_dbg_ready = 1'b1;
    wait_valid(20, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || o_dbg_addr !== e.a || o_dbg_data !== e.d) begin
      n_fail++;
      $display("FAIL stall_beat2: got %h/%h want %h/%h",
               o_dbg_addr, o_dbg_data, e.a, e.d);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_zero_words();
    int d0;
    d0 = done_cnt;
    i_pipe_addr = 32'h600;
    start_dump(32'h999, 8'd0);
    @(negedge i_clk);
    n_checks++;
    if (o_dbg_busy !== 1'b1 || o_dbg_done !== 1'b1 ||
        o_mem_addr !== 32'h600) begin
      n_fail++;
      $display("FAIL zero_done: got b=%b d=%b ma=%h want 1/1/600",
               o_dbg_busy, o_dbg_done, o_mem_addr);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_dbg_busy !== 1'b0 || o_dbg_done !== 1'b0 ||
        done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL zero_after: got b=%b d=%b n=%0d want 0/0/1",
               o_dbg_busy, o_dbg_done, done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    bit   ok;
    exp_t e;
    start_dump(32'hFFFF_FFFC, 8'd2);
    for (int k = 0; k < 2; k++) begin
      wait_valid(20, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || o_dbg_addr !== e.a || o_dbg_data !== e.d) begin
        n_fail++;
        $display("FAIL wrap_beat: got %h/%h want %h/%h",
                 o_dbg_addr, o_dbg_data, e.a, e.d);
      end
    end
    wait_idle(20, ok);
  endtask

  task automatic test_reset_mid();
    bit   ok;
    exp_t e;
    int   d0;
    i_dbg_ready = 1'b0;
    start_dump(32'h80, 8'd3);
    wait_valid(20, ok);
    d0 = done_cnt;
    #1;
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (!ok || o_dbg_valid !== 1'b0 || o_dbg_busy !== 1'b0 ||
        o_dbg_data !== 32'h0 || o_dbg_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got v=%b b=%b %h/%h want 0/0 0/0",
               o_dbg_valid, o_dbg_busy, o_dbg_addr, o_dbg_data);
    end
    sb.delete();
    tick();
    tick();
    i_rst = 1'b1;
    i_dbg_ready = 1'b1;
    i_pipe_req = 1'b1;
    i_pipe_we = 1'b1;
    i_pipe_addr = 32'h700;
    i_pipe_wdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 32'h700 ||
        o_mem_wdata !== 32'hDEAD_BEEF || done_cnt != d0) begin
      n_fail++;
      $display("FAIL rstmid_store: got we=%b %h/%h n=%0d want 1 700/deadbeef %0d",
               o_mem_we, o_mem_addr, o_mem_wdata, done_cnt, d0);
    end
    tick();
    i_pipe_req = 1'b0;
    i_pipe_we = 1'b0;
    start_dump(32'h20, 8'd1);
    wait_valid(20, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || o_dbg_addr !== e.a || o_dbg_data !== e.d) begin
      n_fail++;
      $display("FAIL rstmid_restart: got %h/%h want %h/%h",
               o_dbg_addr, o_dbg_data, e.a, e.d);
    end
    wait_idle(20, ok);
    n_checks++;
    if (!ok || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL rstmid_done: got idle=%b n=%0d want 1/1",
               ok, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pipe_priority();
    test_ready_stall();
    test_zero_words();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
